// File: rtl/i2c_pmon_pkg.sv
// Shared types and constants for the power-monitor I2C responder.
package i2c_pmon_pkg;

  localparam logic [6:0]  DEV_ADDR  = 7'h40;
  localparam logic [15:0] CFG_RESET = 16'h4127;

  localparam logic [2:0] REG_CFG   = 3'd0;
  localparam logic [2:0] REG_SHUNT = 3'd1;
  localparam logic [2:0] REG_BUS   = 3'd2;
  localparam logic [2:0] REG_MASK  = 3'd3;
  localparam logic [2:0] REG_LIMIT = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WR_MSB,
    S_WR_ACK1,
    S_WR_LSB,
    S_WR_ACK2,
    S_RD_MSB,
    S_RD_MACK1,
    S_RD_LSB,
    S_RD_MACK2,
    S_WAIT_STOP
  } state_e;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises raw SCL/SDA and produces single-cycle bus event pulses.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic start_o,
  output logic stop_o,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  // [0] first sync stage, [1] synchronised value, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Two-stage synchroniser plus one history stage; idle bus level is high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o =  scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] &  scl_q[2];
  assign start_o    =  scl_q[1] &  scl_q[2] & ~sda_q[1] &  sda_q[2];
  assign stop_o     =  scl_q[1] &  scl_q[2] &  sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/i2c_pmon_responder.sv
// I2C target emulating the board power monitor: pointer, register file and alert.
//
// state      | meaning
// IDLE       | bus free, waiting for START
// ADDR       | shifting in address + R/W
// ADDR_ACK   | acknowledging our address
// PTR        | shifting in register pointer
// PTR_ACK    | acknowledging pointer byte
// WR_MSB     | shifting in write data MSB
// WR_ACK1    | acknowledging MSB
// WR_LSB     | shifting in write data LSB
// WR_ACK2    | acknowledging LSB, register commits here
// RD_MSB     | driving read data MSB
// RD_MACK1   | master ACK/NACK after MSB
// RD_LSB     | driving read data LSB
// RD_MACK2   | master ACK repeats register, NACK ends
// WAIT_STOP  | not addressed or finished, ignore until START/STOP
module i2c_pmon_responder
  import i2c_pmon_pkg::*;
(
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  input  logic [15:0] meas_shunt,
  input  logic [15:0] meas_bus,
  input  logic        meas_valid,
  output logic        alert_n
);

  logic sda_s, start_p, stop_p, scl_rise, scl_fall;

  i2c_bus_sync u_sync (
    .clk_i      (clk_clk),
    .rst_ni     (reset_reset_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .start_o    (start_p),
    .stop_o     (stop_p),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  state_e      state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  msb_q;
  logic [7:0]  rd_lsb_q;
  logic [2:0]  ptr_q;
  logic        rw_q, phase_q, mack_q, sda_oe_q;

  logic [15:0] cfg_q, shunt_q, bus_q, limit_q;
  logic [15:1] mask_q;
  logic        flag_q;

  logic [7:0]  byte_in;
  logic        last_bit;
  logic [15:0] rd_val;
  logic [15:0] wr_data;
  logic        wr_commit, alert_set, alert_clr;

  assign byte_in   = {shift_q[6:0], sda_s};
  assign last_bit  = (bit_cnt_q == 3'd7);
  assign wr_data   = {msb_q, shift_q};
  assign wr_commit = (state_q == S_WR_ACK2) && phase_q && scl_rise;
  assign alert_clr = (state_q == S_RD_LSB) && scl_rise && last_bit && (ptr_q == REG_MASK);
  assign alert_set = meas_valid && mask_q[15] && (meas_bus > limit_q);

  // Read mux addressed by the pointer; unused indices read as zero.
  always_comb begin
    rd_val = 16'h0000;
    case (ptr_q)
      REG_CFG:   rd_val = cfg_q;
      REG_SHUNT: rd_val = shunt_q;
      REG_BUS:   rd_val = bus_q;
      REG_MASK:  rd_val = {mask_q, flag_q};
      REG_LIMIT: rd_val = limit_q;
      default:   rd_val = 16'h0000;
    endcase
  end

  // Protocol FSM; ACK/NACK phases use phase_q to count the two SCL falls around the ninth bit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      msb_q     <= 8'h00;
      rd_lsb_q  <= 8'h00;
      ptr_q     <= 3'd0;
      rw_q      <= 1'b0;
      phase_q   <= 1'b0;
      mack_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else if (start_p) begin
      state_q   <= S_ADDR;
      bit_cnt_q <= 3'd0;
      phase_q   <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else if (stop_p) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      sda_oe_q <= 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_PTR, S_WR_MSB, S_WR_LSB: begin
          if (scl_rise) begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              phase_q <= 1'b0;
              case (state_q)
                S_ADDR: begin
                  if (shift_q[6:0] == DEV_ADDR) begin
                    rw_q    <= sda_s;
                    state_q <= S_ADDR_ACK;
                  end else begin
                    state_q <= S_WAIT_STOP;
                  end
                end
                S_PTR: begin
                  ptr_q   <= byte_in[2:0];
                  state_q <= S_PTR_ACK;
                end
                S_WR_MSB: begin
                  msb_q   <= byte_in;
                  state_q <= S_WR_ACK1;
                end
                default: state_q <= S_WR_ACK2;
              endcase
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WR_ACK1, S_WR_ACK2: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= 1'b1;
              phase_q  <= 1'b1;
            end else begin
              phase_q  <= 1'b0;
              sda_oe_q <= 1'b0;
              if (state_q == S_ADDR_ACK && rw_q) begin
                state_q             <= S_RD_MSB;
                {shift_q, rd_lsb_q} <= rd_val;
                sda_oe_q            <= ~rd_val[15];
              end else if (state_q == S_ADDR_ACK) begin
                state_q <= S_PTR;
              end else if (state_q == S_WR_ACK1) begin
                state_q <= S_WR_LSB;
              end else begin
                state_q <= S_WR_MSB;
              end
            end
          end
        end
        S_RD_MSB, S_RD_LSB: begin
          if (scl_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              phase_q <= 1'b0;
              state_q <= (state_q == S_RD_MSB) ? S_RD_MACK1 : S_RD_MACK2;
            end
          end else if (scl_fall) begin
            shift_q  <= {shift_q[6:0], 1'b0};
            sda_oe_q <= ~shift_q[6];
          end
        end
        S_RD_MACK1, S_RD_MACK2: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_q <= 1'b0;
              phase_q  <= 1'b1;
            end else begin
              phase_q <= 1'b0;
              if (!mack_q) begin
                state_q <= S_WAIT_STOP;
              end else if (state_q == S_RD_MACK1) begin
                state_q  <= S_RD_LSB;
                shift_q  <= rd_lsb_q;
                sda_oe_q <= ~rd_lsb_q[7];
              end else begin
                state_q             <= S_RD_MSB;
                {shift_q, rd_lsb_q} <= rd_val;
                sda_oe_q            <= ~rd_val[15];
              end
            end
          end else if (scl_rise && phase_q) begin
            mack_q <= ~sda_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Register file: measurement capture and I2C write commit.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cfg_q   <= CFG_RESET;
      shunt_q <= 16'h0000;
      bus_q   <= 16'h0000;
      mask_q  <= 15'h0000;
      limit_q <= 16'h0000;
    end else begin
      if (meas_valid) begin
        shunt_q <= meas_shunt;
        bus_q   <= meas_bus;
      end
      if (wr_commit) begin
        case (ptr_q)
          REG_CFG:   cfg_q   <= wr_data;
          REG_MASK:  mask_q  <= wr_data[15:1];
          REG_LIMIT: limit_q <= wr_data;
          default: ;
        endcase
      end
    end
  end

  // Alert flag: a new over-limit sample wins over a concurrent read-clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      flag_q <= 1'b0;
    end else if (alert_set) begin
      flag_q <= 1'b1;
    end else if (alert_clr) begin
      flag_q <= 1'b0;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign alert_n = ~flag_q;

endmodule

// File: tb/tb_i2c_pmon_responder.sv
// Bench for i2c_pmon_responder: bit-banged master, register/alert model, per-cycle bus checks.
module tb_i2c_pmon_responder;

  localparam int Q = 6;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_bus;
  logic        sda_oe;
  logic        alert_n;
  logic        meas_valid = 1'b0;
  logic [15:0] meas_shunt = 16'h0000;
  logic [15:0] meas_bus   = 16'h0000;

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk_clk = ~clk_clk;

  i2c_pmon_responder dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .scl_i         (m_scl),
    .sda_i         (sda_bus),
    .sda_oe        (sda_oe),
    .meas_shunt    (meas_shunt),
    .meas_bus      (meas_bus),
    .meas_valid    (meas_valid),
    .alert_n       (alert_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the device-visible state.
  logic [15:0] m_cfg, m_shunt, m_bus, m_limit;
  logic [15:1] m_mask;
  logic        m_flag;
  bit          may_drive = 1'b0;
  bit          chk_alert = 1'b1;
  bit          run_chk   = 1'b0;

  task automatic model_reset();
    m_cfg = 16'h4127; m_shunt = 16'h0; m_bus = 16'h0; m_limit = 16'h0;
    m_mask = 15'h0; m_flag = 1'b0;
  endtask

  task automatic model_write(input logic [2:0] p, input logic [15:0] d);
    case (p)
      3'd0: m_cfg = d;
      3'd3: m_mask = d[15:1];
      3'd4: m_limit = d;
      default: ;
    endcase
  endtask

  function automatic logic [15:0] model_read(input logic [2:0] p);
    case (p)
      3'd0: return m_cfg;
      3'd1: return m_shunt;
      3'd2: return m_bus;
      3'd3: return {m_mask, m_flag};
      3'd4: return m_limit;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk_clk) begin
    if (reset_reset_n && meas_valid) begin
      m_shunt = meas_shunt;
      m_bus   = meas_bus;
      if (m_mask[15] && meas_bus > m_limit) m_flag = 1'b1;
    end
  end

  // Per-cycle compare: no SDA pull outside ACK/read windows, alert_n follows the model flag.
  always @(negedge clk_clk) begin
    if (run_chk) begin
      if (!may_drive) begin
        n_cmp++;
        if (sda_oe !== 1'b0) begin
          n_bad++;
          $display("FAIL sda_oe_window at %0t: got %b required 0", $time, sda_oe);
        end
      end
      if (chk_alert) begin
        n_cmp++;
        if (alert_n !== ~m_flag) begin
          n_bad++;
          $display("FAIL alert_n_model at %0t: got %b required %b", $time, alert_n, ~m_flag);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk_clk);
    #1;
  endtask

  task automatic i2c_start();
    if (!m_scl) begin
      wait_clk(Q); m_sda = 1'b1; may_drive = 1'b0;
      wait_clk(Q); m_scl = 1'b1;
    end
    wait_clk(Q); m_sda = 1'b0;
    wait_clk(Q); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(Q); m_sda = 1'b0; may_drive = 1'b0;
    wait_clk(Q); m_scl = 1'b1;
    wait_clk(Q); m_sda = 1'b1;
    wait_clk(4 * Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit exp_ack, input string name);
    logic ack;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(Q); m_sda = b[i]; may_drive = 1'b0;
      wait_clk(Q); m_scl = 1'b1;
      wait_clk(2 * Q); m_scl = 1'b0;
    end
    may_drive = exp_ack;
    wait_clk(Q); m_sda = 1'b1;
    wait_clk(Q); m_scl = 1'b1;
    wait_clk(Q); ack = ~sda_bus;
    wait_clk(Q); m_scl = 1'b0;
    check(name, 16'(ack), 16'(exp_ack));
  endtask

  task automatic read_byte(output logic [7:0] b, input bit master_ack);
    m_sda = 1'b1; may_drive = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clk(2 * Q); m_scl = 1'b1;
      wait_clk(Q); b[i] = sda_bus;
      wait_clk(Q); m_scl = 1'b0;
    end
    wait_clk(Q); m_sda = ~master_ack; may_drive = 1'b0;
    wait_clk(Q); m_scl = 1'b1;
    wait_clk(2 * Q); m_scl = 1'b0;
  endtask

  task automatic reg_write(input logic [6:0] addr, input logic [7:0] ptr,
                           input logic [15:0] d, input string name);
    bit hit;
    hit = (addr == 7'h40);
    i2c_start();
    write_byte({addr, 1'b0}, hit, {name, "_a"});
    write_byte(ptr, hit, {name, "_p"});
    write_byte(d[15:8], hit, {name, "_m"});
    write_byte(d[7:0], hit, {name, "_l"});
    i2c_stop();
    if (hit) model_write(ptr[2:0], d);
  endtask

  task automatic reg_read(input logic [7:0] ptr, input int words, input string name,
                          output logic [15:0] val);
    logic [7:0]  hi, lo;
    logic [15:0] exp;
    bit          clr;
    clr = (ptr[2:0] == 3'd3);
    i2c_start();
    write_byte(8'h80, 1'b1, {name, "_aw"});
    write_byte(ptr, 1'b1, {name, "_p"});
    i2c_start();
    write_byte(8'h81, 1'b1, {name, "_ar"});
    for (int w = 0; w < words; w++) begin
      exp = model_read(ptr[2:0]);
      read_byte(hi, 1'b1);
      if (clr) chk_alert = 1'b0;
      read_byte(lo, w != words - 1);
      if (clr) begin m_flag = 1'b0; chk_alert = 1'b1; end
      val = {hi, lo};
      check({name, "_data"}, val, exp);
    end
    i2c_stop();
  endtask

  task automatic strobe(input logic [15:0] sh, input logic [15:0] bs);
    meas_shunt = sh; meas_bus = bs; meas_valid = 1'b1;
    wait_clk(1);
    meas_valid = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] v;
    logic [7:0]  hi;
    model_reset();
    wait_clk(3);
    check("rst_sda_oe", 16'(sda_oe), 16'h0);
    check("rst_alert_n", 16'(alert_n), 16'h1);
    reset_reset_n = 1'b1;
    run_chk = 1'b1;
    wait_clk(5);

    reg_read(8'h00, 1, "cfg_rst", v);
    check("cfg_rst_lit", v, 16'h4127);

    reg_write(7'h40, 8'h04, 16'h1234, "wr_lim");
    reg_read(8'h04, 1, "rd_lim", v);
    check("lim_lit", v, 16'h1234);

    reg_write(7'h41, 8'h04, 16'h5678, "wr_bad");
    reg_read(8'h04, 1, "rd_lim2", v);
    check("lim_unch_lit", v, 16'h1234);

    strobe(16'h0ABC, 16'h2000);
    reg_read(8'h02, 1, "rd_bus", v);
    check("bus_lit", v, 16'h2000);
    reg_read(8'h01, 1, "rd_shunt", v);
    check("shunt_lit", v, 16'h0ABC);

    reg_write(7'h40, 8'h03, 16'h8000, "wr_mask");
    reg_write(7'h40, 8'h04, 16'h1000, "wr_lim3");
    strobe(16'h0001, 16'h1001);
    check("alert_set_lit", 16'(alert_n), 16'h0);
    reg_read(8'h03, 1, "rd_mask", v);
    check("mask_flag_lit", v, 16'h8001);
    check("alert_clr_lit", 16'(alert_n), 16'h1);

    strobe(16'h0002, 16'h1000);
    check("alert_eq_lit", 16'(alert_n), 16'h1);

    reg_write(7'h40, 8'h01, 16'hFFFF, "wr_ro");
    reg_read(8'h01, 1, "rd_ro", v);
    check("ro_lit", v, 16'h0002);
    reg_write(7'h40, 8'h05, 16'hBEEF, "wr_r5");
    reg_read(8'h05, 1, "rd_r5", v);
    check("r5_lit", v, 16'h0000);
    reg_write(7'h40, 8'h03, 16'hFFFF, "wr_mask2");
    reg_read(8'h03, 1, "rd_mask2", v);
    check("mask_ro_bit_lit", v, 16'hFFFE);
    reg_write(7'h40, 8'h00, 16'hA5C3, "wr_cfg");
    reg_read(8'h00, 1, "rd_cfg", v);

    i2c_start();
    write_byte(8'h80, 1'b1, "rs_a");
    write_byte(8'h04, 1'b1, "rs_p");
    write_byte(8'hAB, 1'b1, "rs_m");
    i2c_start();
    write_byte(8'h80, 1'b1, "rs_a2");
    write_byte(8'h04, 1'b1, "rs_p2");
    i2c_stop();
    reg_read(8'h04, 1, "rd_rs", v);
    check("rs_lit", v, 16'h1000);

    reg_read(8'h00, 2, "rd_rep", v);

    reg_write(7'h40, 8'h0C, 16'h0F0F, "wr_hiptr");
    reg_read(8'h0C, 1, "rd_hiptr", v);
    check("hiptr_lit", v, 16'h0F0F);

    reg_write(7'h40, 8'h03, 16'h0000, "wr_mask0");
    strobe(16'h0003, 16'hFFFF);
    check("alert_masked_lit", 16'(alert_n), 16'h1);

    reg_write(7'h40, 8'h00, 16'h1357, "wr_cfg2");
    i2c_start();
    write_byte(8'h81, 1'b1, "rst_a");
    read_byte(hi, 1'b1);
    check("rst_msb", 16'(hi), 16'h0013);
    m_sda = 1'b1; may_drive = 1'b1;
    wait_clk(5);
    check("rst_pre_oe", 16'(sda_oe), 16'h1);
    reset_reset_n = 1'b0;
    #1;
    check("rst_async_oe", 16'(sda_oe), 16'h0);
    model_reset();
    wait_clk(3);
    reset_reset_n = 1'b1;
    wait_clk(2);
    i2c_stop();
    reg_write(7'h40, 8'h04, 16'h0055, "wr_post");
    reg_read(8'h04, 1, "rd_post", v);
    check("post_lim_lit", v, 16'h0055);
    reg_read(8'h00, 1, "rd_post_cfg", v);
    check("post_cfg_lit", v, 16'h4127);

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
